coords_seq: RTL

//  Sequencer for the 16x36 coords ROM (synchronous pROM, 1-cycle read latency).
//  - On start, walks ROM addresses from 0 upward, one word per fetch.
//  - Hands each word to game logic over a valid/ready handshake.
//  - Ends the pass on an all-zero terminator word or at LAST_ADDR; game logic never drives ROM pins.

---
 rtl/coords_pkg.sv | 9 +
 rtl/coords_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/coords_pkg.sv
// coords_pkg: shared defaults, terminator word and state encoding for coords_seq
package coords_pkg;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 36;
   localparam int DEF_LAST_ADDR = 15;
   localparam int DEF_ROM_LAT = 1;
   localparam logic [DEF_DATA_W-1:0] TERM_WORD = 36'h0;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, VALID, DONE} state_t;
endpackage

// File: rtl/coords_seq.sv
// coords_seq: coords ROM walker with valid/ready output; COORDS_SEQ_WRAP_EN makes the pass loop endlessly
module coords_seq
   import coords_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LAST_ADDR = DEF_LAST_ADDR,
   parameter int ROM_LAT = DEF_ROM_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] rd_index,
   output logic              busy,
   output logic              done,
   output logic              rom_ce,
   output logic              rom_oce,
   output logic [ADDR_W-1:0] rom_ad,
   input  logic [DATA_W-1:0] rom_dout
);
   localparam int LAT_W = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
   state_t state, state_n;
   logic [ADDR_W-1:0] addr, addr_n, index_n;
   logic [LAT_W-1:0] lat_cnt, lat_n;
   logic [DATA_W-1:0] data_n;
   logic valid_n;
   assign rom_oce = 1'b1;
   assign rom_ad = addr;
   always_comb begin
      state_n = state;
      addr_n = addr;
      lat_n = lat_cnt;
      valid_n = rd_valid;
      data_n = rd_data;
      index_n = rd_index;
      if (abort) begin
         state_n = IDLE;
         valid_n = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state_n = FETCH;
               addr_n = '0;
            end
            FETCH: begin
               lat_n = LAT_W'(ROM_LAT - 1);
               state_n = WAIT;
            end
            WAIT: if (lat_cnt != '0) begin
               lat_n = lat_cnt - 1'b1;
            end else if (rom_dout == DATA_W'(TERM_WORD)) begin
`ifdef COORDS_SEQ_WRAP_EN
               addr_n = '0;
               state_n = FETCH;
`else
               state_n = DONE;
`endif
            end else begin
               data_n = rom_dout;
               index_n = addr;
               valid_n = 1'b1;
               state_n = VALID;
            end
            VALID: if (rd_ready) begin
               valid_n = 1'b0;
               if (addr == ADDR_W'(LAST_ADDR)) begin
`ifdef COORDS_SEQ_WRAP_EN
                  addr_n = '0;
                  state_n = FETCH;
`else
                  state_n = DONE;
`endif
               end else begin
                  addr_n = addr + 1'b1;
                  state_n = FETCH;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
   // Status outputs are registered from the next state so they line up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         addr <= '0;
         lat_cnt <= '0;
         rd_valid <= 1'b0;
         rd_data <= '0;
         rd_index <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         rom_ce <= 1'b0;
      end else begin
         state <= state_n;
         addr <= addr_n;
         lat_cnt <= lat_n;
         rd_valid <= valid_n;
         rd_data <= data_n;
         rd_index <= index_n;
         busy <= state_n == FETCH || state_n == WAIT || state_n == VALID;
         done <= state_n == DONE;
         rom_ce <= state_n == FETCH;
      end
   end
endmodule
